// File: rtl/vme_cycle_sequencer_if.sv
// vme_cycle_sequencer_if
//   Groups the command-side handshake and the local VME bus of the cycle
//   sequencer into one bundle.
//   master : the sequencer view (takes commands, drives AS/DS/address/data)
//   slave  : the environment view (issues commands, answers as a VME slave)
// Signals
//   start, vme_cmd_reg[31:0], vme_dat_reg_in[31:0]   command in
//   vme_cmd_rd, vme_dat_wr, vme_dat_reg_out[31:0]     command handshake / result
//   vme_adr[22:0], vme_as_n, vme_ds_n, vme_write_n,
//   vme_d_out[15:0], vme_d_oe                          bus outputs
//   vme_d_in[15:0], vme_dtack_n                        bus inputs
interface vme_cycle_sequencer_if;
    logic        start;
    logic [31:0] vme_cmd_reg;
    logic [31:0] vme_dat_reg_in;
    logic        vme_cmd_rd;
    logic        vme_dat_wr;
    logic [31:0] vme_dat_reg_out;
    logic [22:0] vme_adr;
    logic        vme_as_n;
    logic        vme_ds_n;
    logic        vme_write_n;
    logic [15:0] vme_d_out;
    logic        vme_d_oe;
    logic [15:0] vme_d_in;
    logic        vme_dtack_n;

    modport master (
        input  start, vme_cmd_reg, vme_dat_reg_in, vme_d_in, vme_dtack_n,
        output vme_cmd_rd, vme_dat_wr, vme_dat_reg_out, vme_adr, vme_as_n,
               vme_ds_n, vme_write_n, vme_d_out, vme_d_oe
    );

    modport slave (
        output start, vme_cmd_reg, vme_dat_reg_in, vme_d_in, vme_dtack_n,
        input  vme_cmd_rd, vme_dat_wr, vme_dat_reg_out, vme_adr, vme_as_n,
               vme_ds_n, vme_write_n, vme_d_out, vme_d_oe
    );
endinterface

// File: rtl/vme_cycle_sequencer.sv
// vme_cycle_sequencer
//   Runs one VME slave-bus cycle per accepted command: address + AS for
//   SETUP_CYCLES, then DS until the synchronized DTACK arrives (or a timeout),
//   then releases the strobes, waits for DTACK to drop (or a timeout) and
//   reports the result with a one-cycle vme_dat_wr pulse.
// Ports
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    vme_cycle_sequencer_if.master (command handshake + local VME bus)
// Result word: [15:0] data, [16] write, [30] illegal command, [31] timeout.
module vme_cycle_sequencer #(
    parameter int SETUP_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                         clk,
    input  logic                         rst_n,
    vme_cycle_sequencer_if.master        bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_RELEASE,
        S_REPORT
    } state_t;

    localparam logic [3:0]  SETUP_LAST = 4'(SETUP_CYCLES - 1);
    localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_reg, state_next;

    logic        dtack_meta_reg;
    logic        dtack_s_reg;

    logic [3:0]  setup_cnt_reg, setup_cnt_next;
    logic [15:0] tmo_cnt_reg, tmo_cnt_next;

    logic [22:0] adr_reg, adr_next;
    logic        as_n_reg, as_n_next;
    logic        ds_n_reg, ds_n_next;
    logic        write_n_reg, write_n_next;
    logic [15:0] d_out_reg, d_out_next;
    logic        d_oe_reg, d_oe_next;

    logic        is_write_reg, is_write_next;
    logic [15:0] result_data_reg, result_data_next;
    logic        timeout_reg, timeout_next;
    logic        illegal_reg, illegal_next;

    logic        cmd_rd_reg, cmd_rd_next;
    logic        dat_wr_reg, dat_wr_next;
    logic [31:0] dat_out_reg, dat_out_next;

    logic        enter_report;

    // DTACK is asynchronous to clk. The synchronizer powers up as "acked" so
    // that vme_cmd_rd only rises after the bus has actually been seen idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dtack_meta_reg <= 1'b1;
            dtack_s_reg    <= 1'b1;
        end else begin
            dtack_meta_reg <= ~bus.vme_dtack_n;
            dtack_s_reg    <= dtack_meta_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= S_IDLE;
            setup_cnt_reg   <= '0;
            tmo_cnt_reg     <= '0;
            adr_reg         <= '0;
            as_n_reg        <= 1'b1;
            ds_n_reg        <= 1'b1;
            write_n_reg     <= 1'b1;
            d_out_reg       <= '0;
            d_oe_reg        <= 1'b0;
            is_write_reg    <= 1'b0;
            result_data_reg <= '0;
            timeout_reg     <= 1'b0;
            illegal_reg     <= 1'b0;
            cmd_rd_reg      <= 1'b0;
            dat_wr_reg      <= 1'b0;
            dat_out_reg     <= '0;
        end else begin
            state_reg       <= state_next;
            setup_cnt_reg   <= setup_cnt_next;
            tmo_cnt_reg     <= tmo_cnt_next;
            adr_reg         <= adr_next;
            as_n_reg        <= as_n_next;
            ds_n_reg        <= ds_n_next;
            write_n_reg     <= write_n_next;
            d_out_reg       <= d_out_next;
            d_oe_reg        <= d_oe_next;
            is_write_reg    <= is_write_next;
            result_data_reg <= result_data_next;
            timeout_reg     <= timeout_next;
            illegal_reg     <= illegal_next;
            cmd_rd_reg      <= cmd_rd_next;
            dat_wr_reg      <= dat_wr_next;
            dat_out_reg     <= dat_out_next;
        end
    end

    // All bus outputs are registers: each branch sets the value the bus must
    // show in the state being entered.
    always_comb begin
        state_next       = state_reg;
        setup_cnt_next   = setup_cnt_reg;
        tmo_cnt_next     = tmo_cnt_reg;
        adr_next         = adr_reg;
        as_n_next        = as_n_reg;
        ds_n_next        = ds_n_reg;
        write_n_next     = write_n_reg;
        d_out_next       = d_out_reg;
        d_oe_next        = d_oe_reg;
        is_write_next    = is_write_reg;
        result_data_next = result_data_reg;
        timeout_next     = timeout_reg;
        illegal_next     = illegal_reg;
        dat_wr_next      = 1'b0;
        dat_out_next     = dat_out_reg;
        enter_report     = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (bus.start && cmd_rd_reg) begin
                    timeout_next = 1'b0;
                    if (bus.vme_cmd_reg[24] ^ bus.vme_cmd_reg[25]) begin
                        illegal_next     = 1'b0;
                        is_write_next    = bus.vme_cmd_reg[24];
                        result_data_next = bus.vme_cmd_reg[24] ? bus.vme_dat_reg_in[15:0] : 16'h0000;
                        adr_next         = bus.vme_cmd_reg[23:1];
                        as_n_next        = 1'b0;
                        write_n_next     = ~bus.vme_cmd_reg[24];
                        if (bus.vme_cmd_reg[24]) begin
                            d_out_next = bus.vme_dat_reg_in[15:0];
                            d_oe_next  = 1'b1;
                        end
                        setup_cnt_next = '0;
                        state_next     = S_SETUP;
                    end else begin
                        // Both or neither direction bit: report without touching the bus.
                        illegal_next     = 1'b1;
                        is_write_next    = 1'b0;
                        result_data_next = 16'h0000;
                        enter_report     = 1'b1;
                        state_next       = S_REPORT;
                    end
                end
            end

            S_SETUP: begin
                if (setup_cnt_reg == SETUP_LAST) begin
                    ds_n_next    = 1'b0;
                    tmo_cnt_next = '0;
                    state_next   = S_STROBE;
                end else begin
                    setup_cnt_next = setup_cnt_reg + 4'd1;
                end
            end

            S_STROBE: begin
                // Ack is tested first so a simultaneous timeout never flags.
                if (dtack_s_reg || (tmo_cnt_reg == TMO_LAST)) begin
                    if (dtack_s_reg) begin
                        if (!is_write_reg) begin
                            result_data_next = bus.vme_d_in;
                        end
                    end else begin
                        timeout_next     = 1'b1;
                        result_data_next = 16'h0000;
                    end
                    as_n_next    = 1'b1;
                    ds_n_next    = 1'b1;
                    write_n_next = 1'b1;
                    d_oe_next    = 1'b0;
                    tmo_cnt_next = '0;
                    state_next   = S_RELEASE;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + 16'd1;
                end
            end

            S_RELEASE: begin
                if (!dtack_s_reg) begin
                    enter_report = 1'b1;
                    state_next   = S_REPORT;
                end else if (tmo_cnt_reg == TMO_LAST) begin
                    // Slave is holding DTACK: give up and flag it.
                    timeout_next = 1'b1;
                    enter_report = 1'b1;
                    state_next   = S_REPORT;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + 16'd1;
                end
            end

            S_REPORT: begin
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (enter_report) begin
            dat_wr_next  = 1'b1;
            dat_out_next = {timeout_next, illegal_next, 13'b0, is_write_next, result_data_next};
        end

        // Registered ready flag tracks the value dtack_s will have next cycle.
        cmd_rd_next = (state_next == S_IDLE) && !dtack_meta_reg;
    end

    assign bus.vme_cmd_rd      = cmd_rd_reg;
    assign bus.vme_dat_wr      = dat_wr_reg;
    assign bus.vme_dat_reg_out = dat_out_reg;
    assign bus.vme_adr         = adr_reg;
    assign bus.vme_as_n        = as_n_reg;
    assign bus.vme_ds_n        = ds_n_reg;
    assign bus.vme_write_n     = write_n_reg;
    assign bus.vme_d_out       = d_out_reg;
    assign bus.vme_d_oe        = d_oe_reg;

endmodule
